hazard_forward_ctrl: RTL

- Control stage that produces the 2-bit operand-select codes driving the EX-stage 3-to-1 operand muxes.
- Tracks destination-register state of the instructions in EX, MEM and WB using its own shadow pipeline.
- Detects load-use hazards and requests a one-cycle stall plus bubble.
- Sits between decode (ID) and the ID/EX pipeline register.
- Select outputs are registered, so they are valid alongside the instruction they apply to in EX.

---
 rtl/hazard_forward_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall controller placed between ID and the ID/EX register.
// Keeps a shadow copy of the destination-register state of EX, MEM and WB.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_WB      = 2'b01;
  localparam logic [1:0] SEL_MEM     = 2'b10;

  stage_t ex_stage;
  stage_t mem_stage;
  stage_t wb_stage;
  stage_t id_stage;

  logic       hazard;
  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;

  function automatic logic stage_writes(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  // Youngest producer wins. A WB producer needs nothing because the register file is write-first.
  function automatic logic [1:0] fwd_code(input logic [REG_AW-1:0] r,
                                          input stage_t ex_s,
                                          input stage_t mem_s,
                                          input stage_t wb_s);
    logic [1:0] code;
    code = SEL_REGFILE;
    if (stage_writes(ex_s, r))
      code = SEL_MEM;
    else if (stage_writes(mem_s, r))
      code = SEL_WB;
    else if (stage_writes(wb_s, r))
      code = SEL_REGFILE;
    return code;
  endfunction

  always_comb begin
    id_stage.valid     = id_valid;
    id_stage.rd        = id_rd;
    id_stage.reg_write = id_reg_write;
    id_stage.mem_read  = id_mem_read;
  end

  always_comb begin
    hazard = ex_stage.valid && ex_stage.mem_read && (ex_stage.rd != '0) && id_valid &&
             ((id_uses_rs && (id_rs == ex_stage.rd)) ||
              (id_uses_rt && (id_rt == ex_stage.rd)));
    // A squashed instruction never needs to wait for its operands.
    stall  = hazard && !branch_flush;
    bubble = stall || branch_flush;
  end

  always_comb begin
    sel_a_next = SEL_REGFILE;
    sel_b_next = SEL_REGFILE;
    if (!bubble && id_valid) begin
      if (id_uses_rs)
        sel_a_next = fwd_code(id_rs, ex_stage, mem_stage, wb_stage);
      if (id_uses_rt)
        sel_b_next = fwd_code(id_rt, ex_stage, mem_stage, wb_stage);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_stage     <= '0;
      mem_stage    <= '0;
      wb_stage     <= '0;
      fwd_sel_a    <= SEL_REGFILE;
      fwd_sel_b    <= SEL_REGFILE;
      stall_cycles <= '0;
    end else begin
      wb_stage  <= mem_stage;
      mem_stage <= ex_stage;
      ex_stage  <= bubble ? '0 : id_stage;
      fwd_sel_a <= sel_a_next;
      fwd_sel_b <= sel_b_next;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
